scan_test_ctrl: RTL
===================

Name: scan_test_ctrl

Overview:
- Scan-test sequencer that sits directly upstream of the 4-bit scan-enabled counter and drives its SE and scan_in inputs.
- Per run: shifts a pattern into the counter's scan chain, releases it for a fixed number of functional clocks, then shifts the chain back out through scan_out.
- Compares the unloaded value against an expected word and reports pass/fail, for on-chip and gate-level (SDF) checks of the counter.

Parameters:
- CHAIN_LEN, 4: number of flops in the scan chain. Must be ≥ 2.
- CAPTURE_CYCLES, 1: number of functional (SE=0) cycles between load and unload. Must be ≥ 1.

Ports:
- clk  input  1  Rising-edge clock, shared with the counter.
- reset  input  1  Synchronous, active-low reset.
- start  input  1  Run request. Sampled only in IDLE.
- pattern  input  CHAIN_LEN  Value to load into the chain. Latched on accepted start.
- expected  input  CHAIN_LEN  Expected unload value. Latched on accepted start.
- scan_out  input  1  Chain output from the counter.
- SE  output  1  Scan enable to the counter. Registered.
- scan_in  output  1  Serial data to the counter. Registered.
- busy  output  1  High while a run is in progress.
- done  output  1  Single-cycle end-of-run pulse.
- pass  output  1  Compare result (captured == expected). Valid from done; held until the next accepted start.
- captured  output  CHAIN_LEN  Unloaded chain value. Held until the next accepted start.

Behaviour:
- Chain order: scan_in → count[0] → count[1] → … → count[CHAIN_LEN-1] = scan_out. Each flop shifts toward the MSB while SE=1.
- Reset:
  - Applies at any clk edge with reset=0, including mid-run.
  - Forces state IDLE, SE=0, scan_in=0, busy=0, done=0, pass=0, captured=0, and clears internal counters.
  - An aborted run produces no done pulse.
- IDLE:
  - SE=0, scan_in=0, busy=0.
  - An edge with start=1 latches pattern/expected, clears captured and pass, and moves to SHIFT_IN.
- SHIFT_IN:
  - Lasts exactly CHAIN_LEN cycles with SE=1 and busy=1.
  - In cycle i (i = 0..CHAIN_LEN-1), scan_in = pattern_latched[CHAIN_LEN-1-i], so the MSB goes first.
  - After the last edge, the counter holds pattern_latched.
- CAPTURE:
  - Lasts exactly CAPTURE_CYCLES cycles with SE=0, scan_in=0, busy=1.
  - The counter counts functionally during these cycles.
- SHIFT_OUT:
  - Lasts exactly CHAIN_LEN cycles with SE=1, scan_in=0, busy=1.
  - At the edge ending each cycle: captured <= {captured[CHAIN_LEN-2:0], scan_out}.
  - The first sample is count[CHAIN_LEN-1], so after CHAIN_LEN edges, captured equals the post-capture counter value.
- DONE:
  - One cycle: done=1, busy=0, SE=0, pass = (captured == expected_latched).
  - Next state is IDLE. start is not accepted in DONE.
- Latency: the first SHIFT_IN cycle immediately follows the start edge. done is asserted in cycle 2·CHAIN_LEN + CAPTURE_CYCLES + 1 after the start edge.
- start while busy or in DONE is ignored. pattern/expected changes mid-run have no effect.
- Internal cycle counters are sized $clog2(max(CHAIN_LEN, CAPTURE_CYCLES)+1) and reload to 0 on each state entry.
- SE and scan_in are glitch-free registered outputs, with no combinational path from any input.
- Synchronous reset only: no asynchronous clear on any flop.

Test Plan:
1. Reset hold: reset=0 for 3 cycles while start=1 → SE=0, scan_in=0, busy=0, done=0, pass=0, captured=4'b0000 throughout.
2. Basic run (CHAIN_LEN=4, CAPTURE_CYCLES=1, connected to counter):
   - Stimulus: pattern=4'b0101, expected=4'b0110, one-cycle start.
   - Required: scan_in sequence 0,1,0,1 with SE=1 for 4 cycles; SE=0 for 1 cycle; SE=1 for 4 cycles; done pulse in cycle 10 after the start edge; captured=4'b0110; pass=1.
3. Wrap-around: pattern=4'b1111, expected=4'b0000, CAPTURE_CYCLES=1 → captured=4'b0000, pass=1.
4. Mismatch: pattern=4'b0011, expected=4'b0011 → captured=4'b0100, pass=0, done pulses once; pass stays 0 until the next start.
5. Start while busy: pulse start again during SHIFT_IN and CAPTURE → no restart; scan_in sequence and done timing identical to scenario 2.
6. Reset mid-run: reset=0 for one edge during SHIFT_OUT → next cycle SE=0, busy=0, captured=0, no done pulse; a new start afterwards completes normally with pass=1 for scenario 2 values.

Source files
------------

// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer for a scan-enabled counter: loads a pattern MSB-first,
// releases the chain for CAPTURE_CYCLES functional clocks, unloads it and compares.
module scan_test_ctrl #(
  parameter int CHAIN_LEN      = 4,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 scan_out,
  output logic                 SE,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] captured
);

  localparam int MAX_CNT = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] LAST_CAP   = CW'(CAPTURE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [CHAIN_LEN-1:0] shreg, shreg_n;
  logic [CHAIN_LEN-1:0] exp_q, exp_n;
  logic [CHAIN_LEN-1:0] cap_n;
  logic                 se_n, sin_n, pass_n;

  // SE/scan_in are computed for the cycle being entered, so they are pure flops.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    exp_n   = exp_q;
    cap_n   = captured;
    pass_n  = pass;
    se_n    = 1'b0;
    sin_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT_IN;
          cnt_n   = '0;
          se_n    = 1'b1;
          sin_n   = pattern[CHAIN_LEN-1];
          shreg_n = {pattern[CHAIN_LEN-2:0], 1'b0};
          exp_n   = expected;
          cap_n   = '0;
          pass_n  = 1'b0;
        end
      end
      SHIFT_IN: begin
        if (cnt == LAST_SHIFT) begin
          state_n = CAPTURE;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + CW'(1);
          se_n    = 1'b1;
          sin_n   = shreg[CHAIN_LEN-1];
          shreg_n = {shreg[CHAIN_LEN-2:0], 1'b0};
        end
      end
      CAPTURE: begin
        if (cnt == LAST_CAP) begin
          state_n = SHIFT_OUT;
          cnt_n   = '0;
          se_n    = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHIFT_OUT: begin
        cap_n = {captured[CHAIN_LEN-2:0], scan_out};
        if (cnt == LAST_SHIFT) begin
          state_n = DONE;
          cnt_n   = '0;
          pass_n  = (cap_n == exp_q);
        end else begin
          cnt_n = cnt + CW'(1);
          se_n  = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      exp_q    <= '0;
      captured <= '0;
      pass     <= 1'b0;
      SE       <= 1'b0;
      scan_in  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      exp_q    <= exp_n;
      captured <= cap_n;
      pass     <= pass_n;
      SE       <= se_n;
      scan_in  <= sin_n;
    end
  end

  assign busy = (state == SHIFT_IN) || (state == CAPTURE) || (state == SHIFT_OUT);
  assign done = (state == DONE);

endmodule
